msg_ram_arb: RTL
================

MSG_RAM_ARB -- requirements
Module: msg_ram_arb

Interface
REQ-001 The block SHALL have parameter DEPTH, default 27, giving the number of valid message RAM entries (addresses 0..DEPTH-1).
REQ-002 The block SHALL have parameter AW, default 5, giving the address width.
REQ-003 The block SHALL have parameter DW, default 24, giving the data width (8 x 3-bit soft messages).
REQ-004 The block SHALL have one clock and a synchronous, active-low reset:
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  reset, synchronous, active-low.
REQ-005 The block SHALL have the following requester ports (bit 0 = check-node unit CNU, bit 1 = variable-node unit VNU):
- rd_req  in  2  read request per requester; held until granted.
- rd_addr  in  2*AW  read address; [AW-1:0] CNU, [2AW-1:AW] VNU.
- rd_gnt  out  2  read grant; one-cycle pulse, request consumed.
- rd_vld  out  2  read data valid for the requester; one-cycle pulse.
- rd_data  out  DW  read data, shared; qualified by rd_vld.
- wr_req  in  2  write request per requester; held until granted.
- wr_addr  in  2*AW  write address, packed as rd_addr.
- wr_data  in  2*DW  write data; [DW-1:0] CNU, [2DW-1:DW] VNU.
- wr_gnt  out  2  write grant; one-cycle pulse.
REQ-006 The block SHALL have the following RAM-side ports (the RAM is edge-triggered on re/we):
- ram_re  out  1  read strobe.
- ram_raddr  out  AW  read address.
- ram_rdata  in  DW  RAM read data.
- ram_we  out  1  write strobe.
- ram_waddr  out  AW  write address.
- ram_wdata  out  DW  write data.
- addr_err  out  1  sticky out-of-range address flag.

Function
REQ-007 The read port SHALL use FSM R_IDLE -> R_ACC -> R_GAP; a read grant SHALL be issued only in R_IDLE or R_GAP.
- After a grant the FSM goes to R_ACC.
- R_ACC always goes to R_GAP.
- R_GAP goes to R_ACC on a new grant, else to R_IDLE.
REQ-008 The write port SHALL use an identical, independent FSM W_IDLE -> W_ACC -> W_GAP.
REQ-009 A read granted in cycle N SHALL drive ram_re=1 and ram_raddr=granted address, registered, for exactly cycle N+1.
- rd_data SHALL be the ram_rdata registered at the end of N+1.
- rd_vld SHALL be set for the granted requester in cycle N+2 only.
- Latency grant->vld = 2 cycles.
REQ-010 A write granted in cycle N SHALL drive ram_we=1 with registered ram_waddr/ram_wdata for exactly cycle N+1.
REQ-011 ram_re and ram_we SHALL each be low for at least one cycle between accesses; maximum throughput is one read and one write every 2 cycles.
REQ-012 At most one read grant and one write grant SHALL be issued per cycle; rd_gnt and wr_gnt SHALL each be zero or one-hot.
REQ-013 Each port SHALL use its own 1-bit round-robin pointer to select between requesters.
- Single requester: granted regardless of the pointer.
- Both requesting: the pointer side wins.
- After any grant, the pointer moves to the non-granted side.
REQ-014 The block SHALL not grant a read in any cycle in which a write is granted to the same address; that read SHALL be granted no earlier than the next eligible cycle.
REQ-015 An address >= DEPTH SHALL still be granted with normal FSM timing, but with no RAM access and addr_err set.
- Read: ram_re stays 0, and rd_vld pulses in N+2 with rd_data=0.
- Write: ram_we stays 0.
REQ-016 rd_data SHALL hold its last value when rd_vld=0.

Reset
REQ-017 When rst_n=0 at a clock edge, the block SHALL return both FSMs to IDLE and both pointers to CNU, and clear all outputs (gnt, vld, rd_data, ram_re, ram_we, ram addresses/data, addr_err) to 0.
- Any in-flight access SHALL be aborted, with no rd_vld pulse.
- Reset SHALL be the only way to clear addr_err.

Verification
REQ-018 The bench SHALL cover a single CNU read: rd_req=01, addr 5, RAM[5]=0xABCDEF -> rd_gnt=01 in cycle 0, ram_re=1 in cycle 1 only, rd_vld=01 and rd_data=0xABCDEF in cycle 2.
REQ-019 The bench SHALL cover continuous reads: both rd_req held for 8 cycles -> grants in cycles 0,2,4,6 alternating 01,10,01,10; ram_re pattern 0101...
REQ-020 The bench SHALL cover a write/read conflict: wr_req=01 and rd_req=10, both at addr 7, in the same cycle -> wr_gnt in cycle 0, rd_gnt no earlier than cycle 1, and the read returns the newly written data.
REQ-021 The bench SHALL cover an out-of-range write: write to addr 27 -> wr_gnt pulses, ram_we stays 0, addr_err=1 from the next cycle until reset.
REQ-022 The bench SHALL cover reset mid-read: rst_n=0 in cycle 1 of a granted read -> no rd_vld, all outputs 0, and the next read after release is granted to CNU first.

Source files
------------

// File: rtl/msg_ram_arb.sv
// msg_ram_arb: round-robin CNU/VNU arbiter onto a message RAM with independent read and write ports.
// Each port alternates access and gap cycles; out-of-range addresses are granted but never reach the RAM.
module msg_ram_arb #(
    parameter int DEPTH = 27,
    parameter int AW    = 5,
    parameter int DW    = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      rd_req,
    input  logic [2*AW-1:0] rd_addr,
    output logic [1:0]      rd_gnt,
    output logic [1:0]      rd_vld,
    output logic [DW-1:0]   rd_data,
    input  logic [1:0]      wr_req,
    input  logic [2*AW-1:0] wr_addr,
    input  logic [2*DW-1:0] wr_data,
    output logic [1:0]      wr_gnt,
    output logic            ram_re,
    output logic [AW-1:0]   ram_raddr,
    input  logic [DW-1:0]   ram_rdata,
    output logic            ram_we,
    output logic [AW-1:0]   ram_waddr,
    output logic [DW-1:0]   ram_wdata,
    output logic            addr_err
);
    typedef enum logic [1:0] {R_IDLE, R_ACC, R_GAP} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_ACC, W_GAP} wstate_t;
    localparam logic [AW:0] LIM = (AW+1)'(DEPTH);
    rstate_t r_state, r_next;
    wstate_t w_state, w_next;
    logic r_ptr, w_ptr, r_sel, w_sel, r_ok, w_ok, r_oor, w_oor, r_id, r_bad;
    logic [AW-1:0] r_a, w_a;
    always_comb begin
        w_sel  = (wr_req == 2'b11) ? w_ptr : wr_req[1];
        r_sel  = (rd_req == 2'b11) ? r_ptr : rd_req[1];
        w_a    = w_sel ? wr_addr[2*AW-1:AW] : wr_addr[AW-1:0];
        r_a    = r_sel ? rd_addr[2*AW-1:AW] : rd_addr[AW-1:0];
        w_oor  = {1'b0, w_a} >= LIM;
        r_oor  = {1'b0, r_a} >= LIM;
        w_ok   = rst_n && (w_state != W_ACC) && (|wr_req);
        // a read colliding with this cycle's write waits so it returns the new data
        r_ok   = rst_n && (r_state != R_ACC) && (|rd_req) && !(w_ok && (w_a == r_a));
        wr_gnt = w_ok ? (w_sel ? 2'b10 : 2'b01) : 2'b00;
        rd_gnt = r_ok ? (r_sel ? 2'b10 : 2'b01) : 2'b00;
        w_next = (w_state == W_ACC) ? W_GAP : (w_ok ? W_ACC : W_IDLE);
        r_next = (r_state == R_ACC) ? R_GAP : (r_ok ? R_ACC : R_IDLE);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
        end else begin
            r_state <= r_next;
            w_state <= w_next;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr     <= 1'b0;
            w_ptr     <= 1'b0;
            r_id      <= 1'b0;
            r_bad     <= 1'b0;
            ram_re    <= 1'b0;
            ram_we    <= 1'b0;
            ram_raddr <= '0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            rd_vld    <= 2'b00;
            rd_data   <= '0;
            addr_err  <= 1'b0;
        end else begin
            ram_re   <= r_ok && !r_oor;
            ram_we   <= w_ok && !w_oor;
            addr_err <= addr_err || (r_ok && r_oor) || (w_ok && w_oor);
            if (r_ok) begin
                ram_raddr <= r_a;
                r_ptr     <= !r_sel;
                r_id      <= r_sel;
                r_bad     <= r_oor;
            end
            if (w_ok) begin
                ram_waddr <= w_a;
                ram_wdata <= w_sel ? wr_data[2*DW-1:DW] : wr_data[DW-1:0];
                w_ptr     <= !w_sel;
            end
            rd_vld <= (r_state == R_ACC) ? (r_id ? 2'b10 : 2'b01) : 2'b00;
            if (r_state == R_ACC)
                rd_data <= r_bad ? '0 : ram_rdata;
        end
    end
endmodule
